// File: rtl/pc_sequencer_pkg.sv
// Shared redirect codes and sequencer FSM states for the fetch-side PC sequencer.
package pc_sequencer_pkg;

    localparam logic [1:0] PCSRC_SEQ   = 2'b00;
    localparam logic [1:0] PCSRC_EXC   = 2'b01;
    localparam logic [1:0] PCSRC_TAKEN = 2'b10;
    localparam logic [1:0] PCSRC_HALT  = 2'b11;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect/fetch bundle between branch resolution and the PC sequencer.
// Optional exc_pc/epc signals exist only when PC_EPC_EN is defined.
interface pc_sequencer_if #(
    parameter int unsigned PC_W = 32
);
    logic [1:0]      PC_src;
    logic [PC_W-1:0] branch_target;
    logic            stall;
    logic [PC_W-1:0] PC;
    logic            fetch_valid;
    logic            flush;
    logic            halted;
`ifdef PC_EPC_EN
    logic [PC_W-1:0] exc_pc;
    logic [PC_W-1:0] epc;

    modport master (
        output PC_src, branch_target, stall, exc_pc,
        input  PC, fetch_valid, flush, halted, epc
    );

    modport slave (
        input  PC_src, branch_target, stall, exc_pc,
        output PC, fetch_valid, flush, halted, epc
    );
`else
    modport master (
        output PC_src, branch_target, stall,
        input  PC, fetch_valid, flush, halted
    );

    modport slave (
        input  PC_src, branch_target, stall,
        output PC, fetch_valid, flush, halted
    );
`endif
endinterface

// File: rtl/pc_sequencer_next_mux.sv
// Combinational next-PC priority select: exception > halt > taken > stall > sequential.
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W       = 32,
    parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0100,
    parameter logic [PC_W-1:0] PC_INC     = 32'd1
) (
    input  logic [1:0]      PC_src,
    input  logic            stall,
    input  logic [PC_W-1:0] PC,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] next_pc,
    output logic            redirect,
    output logic            halt_req
);

    always_comb begin
        next_pc  = PC;
        redirect = 1'b0;
        halt_req = 1'b0;
        if (PC_src == PCSRC_EXC) begin
            next_pc  = EXC_VECTOR;
            redirect = 1'b1;
        end else if (PC_src == PCSRC_HALT) begin
            halt_req = 1'b1;
        end else if (PC_src == PCSRC_TAKEN) begin
            next_pc  = branch_target;
            redirect = 1'b1;
        end else if (!stall) begin
            // wraps modulo 2^PC_W by construction
            next_pc = PC + PC_INC;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, boot/run/halt FSM and registered flush for the fetch stage.
// Optional macro PC_EPC_EN adds the exception-PC capture register (exc_pc -> epc).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0100,
    parameter logic [PC_W-1:0] PC_INC     = 32'd1
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);

    seq_state_t      state, state_next;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            flush_q, flush_d;
    logic            halted_q, halted_d;
    logic [PC_W-1:0] mux_pc;
    logic            mux_redirect;
    logic            mux_halt;

    pc_next_mux #(
        .PC_W       (PC_W),
        .EXC_VECTOR (EXC_VECTOR),
        .PC_INC     (PC_INC)
    ) u_next_mux (
        .PC_src        (bus.PC_src),
        .stall         (bus.stall),
        .PC            (pc_q),
        .branch_target (bus.branch_target),
        .next_pc       (mux_pc),
        .redirect      (mux_redirect),
        .halt_req      (mux_halt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state         <= state_next;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            halted_q      <= halted_d;
        end
    end

    always_comb begin
        state_next    = state;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        flush_d       = 1'b0;
        halted_d      = halted_q;
        case (state)
            S_BOOT: begin
                state_next    = S_RUN;
                fetch_valid_d = 1'b1;
            end
            S_RUN: begin
                if (mux_halt) begin
                    state_next    = S_HALT;
                    flush_d       = 1'b1;
                    halted_d      = 1'b1;
                    fetch_valid_d = 1'b0;
                end else begin
                    pc_d    = mux_pc;
                    flush_d = mux_redirect;
                end
            end
            S_HALT: begin
                fetch_valid_d = 1'b0;
                halted_d      = 1'b1;
            end
            default: state_next = S_BOOT;
        endcase
    end

`ifdef PC_EPC_EN
    logic [PC_W-1:0] epc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epc_q <= '0;
        end else if (state == S_RUN && bus.PC_src == PCSRC_EXC) begin
            epc_q <= bus.exc_pc;
        end
    end

    assign bus.epc = epc_q;
`endif

    assign bus.PC          = pc_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.flush       = flush_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle model comparison plus literal spot checks.
module tb_pc_sequencer;

    localparam int unsigned PC_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    pc_sequencer_if #(.PC_W(PC_W)) bus ();

    pc_sequencer #(
        .PC_W       (PC_W),
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0100),
        .PC_INC     (32'd1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: booted/halted flags and plain arithmetic on the PC
    logic [31:0] m_pc = '0;
    logic        m_fv = 1'b0;
    logic        m_flush = 1'b0;
    logic        m_halted = 1'b0;
    logic        m_booted = 1'b0;
    logic [31:0] m_epc = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc     <= 32'h0;
            m_fv     <= 1'b0;
            m_flush  <= 1'b0;
            m_halted <= 1'b0;
            m_booted <= 1'b0;
            m_epc    <= 32'h0;
        end else if (m_halted) begin
            m_flush <= 1'b0;
        end else if (!m_booted) begin
            m_booted <= 1'b1;
            m_fv     <= 1'b1;
            m_flush  <= 1'b0;
        end else begin
            case (bus.PC_src)
                2'b01: begin
                    m_pc    <= 32'h100;
                    m_flush <= 1'b1;
`ifdef PC_EPC_EN
                    m_epc   <= bus.exc_pc;
`endif
                end
                2'b11: begin
                    m_halted <= 1'b1;
                    m_fv     <= 1'b0;
                    m_flush  <= 1'b1;
                end
                2'b10: begin
                    m_pc    <= bus.branch_target;
                    m_flush <= 1'b1;
                end
                default: begin
                    m_flush <= 1'b0;
                    if (!bus.stall) m_pc <= m_pc + 32'd1;
                end
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_pc", bus.PC, m_pc);
            check("cyc_fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, m_fv});
            check("cyc_flush", {31'd0, bus.flush}, {31'd0, m_flush});
            check("cyc_halted", {31'd0, bus.halted}, {31'd0, m_halted});
`ifdef PC_EPC_EN
            check("cyc_epc", bus.epc, m_epc);
`endif
        end
    end

    task automatic step(input logic [1:0] src, input logic [31:0] tgt, input logic st);
        bus.PC_src        = src;
        bus.branch_target = tgt;
        bus.stall         = st;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic fv,
                              input logic fl, input logic h);
        check({tag, "_pc"}, bus.PC, pc);
        check({tag, "_fv"}, {31'd0, bus.fetch_valid}, {31'd0, fv});
        check({tag, "_flush"}, {31'd0, bus.flush}, {31'd0, fl});
        check({tag, "_halted"}, {31'd0, bus.halted}, {31'd0, h});
    endtask

    initial begin
        bus.PC_src        = 2'b00;
        bus.branch_target = '0;
        bus.stall         = 1'b0;
`ifdef PC_EPC_EN
        bus.exc_pc        = '0;
`endif
        #2 rst = 1'b0;
        #10;
        expect_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        @(posedge clk); #1 rst = 1'b1;

        // boot then sequential fetch
        step(2'b00, 32'h0, 1'b0);  expect_out("boot", 32'h0, 1'b1, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b0);  expect_out("seq1", 32'h1, 1'b1, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b0);
        step(2'b00, 32'h0, 1'b0);  expect_out("seq3", 32'h3, 1'b1, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b0);
        step(2'b00, 32'h0, 1'b0);  check("at5", bus.PC, 32'h5);

        // taken branch, then sequential again
        step(2'b10, 32'h40, 1'b0); expect_out("br40", 32'h40, 1'b1, 1'b1, 1'b0);
        step(2'b00, 32'h0, 1'b0);  expect_out("br41", 32'h41, 1'b1, 1'b0, 1'b0);

        // redirect beats stall, then plain stall holds
        step(2'b10, 32'h20, 1'b1); expect_out("brstall", 32'h20, 1'b1, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 3; i++) begin
            step(2'b00, 32'h0, 1'b1);
            expect_out("stall", 32'h20, 1'b1, 1'b0, 1'b0);
        end

        // exception redirect, immediately followed by a branch
`ifdef PC_EPC_EN
        bus.exc_pc = 32'h7;
`endif
        step(2'b01, 32'h0, 1'b1);  expect_out("exc", 32'h100, 1'b1, 1'b1, 1'b0);
`ifdef PC_EPC_EN
        check("exc_epc", bus.epc, 32'h7);
        bus.exc_pc = 32'h99;
`endif
        step(2'b10, 32'h3, 1'b0);  expect_out("b2b", 32'h3, 1'b1, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 6; i++) step(2'b00, 32'h0, 1'b0);
        check("at9", bus.PC, 32'h9);

        // halt is sticky and ignores every input
        step(2'b11, 32'h0, 1'b0);  expect_out("halt", 32'h9, 1'b0, 1'b1, 1'b1);
        step(2'b10, 32'h55, 1'b0); expect_out("halt_br", 32'h9, 1'b0, 1'b0, 1'b1);
        step(2'b01, 32'h0, 1'b1);  expect_out("halt_exc", 32'h9, 1'b0, 1'b0, 1'b1);
        step(2'b00, 32'h0, 1'b0);  expect_out("halt_seq", 32'h9, 1'b0, 1'b0, 1'b1);
`ifdef PC_EPC_EN
        check("halt_epc", bus.epc, 32'h7);
`endif
        #3 rst = 1'b0;
        #1 expect_out("halt_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        step(2'b00, 32'h0, 1'b0);  expect_out("reboot", 32'h0, 1'b1, 1'b0, 1'b0);

        // wrap at top of address space
        step(2'b10, 32'hFFFF_FFFF, 1'b0); expect_out("brtop", 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        step(2'b00, 32'h0, 1'b0);  expect_out("wrap", 32'h0, 1'b1, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b0);  check("postwrap", bus.PC, 32'h1);

        // asynchronous reset mid-stream, between clock edges
        step(2'b10, 32'h1234, 1'b0); expect_out("br1234", 32'h1234, 1'b1, 1'b1, 1'b0);
        #3 rst = 1'b0;
        #1 expect_out("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef PC_EPC_EN
        check("async_epc", bus.epc, 32'h0);
`endif
        @(posedge clk); #1 rst = 1'b1;
        step(2'b00, 32'h0, 1'b0);
        step(2'b00, 32'h0, 1'b0);  expect_out("resume", 32'h1, 1'b1, 1'b0, 1'b0);
        step(2'b11, 32'h0, 1'b1);  expect_out("halt_stall", 32'h1, 1'b0, 1'b1, 1'b1);
        step(2'b00, 32'h0, 1'b0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
